// File: rtl/rpc_dev_pkg.sv
// Shared types for the RPC DRAM device-side responder: opcodes, FSM states
// and the decoded command record handed to the backend.
package rpc_dev_pkg;

  typedef enum logic [3:0] {
    OP_WRITE = 4'h1,
    OP_READ  = 4'h2
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD1,
    WR_DATA,
    RD_WAIT,
    RD_PRE,
    RD_DATA,
    RD_POST
  } state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] bank;
    logic [9:0] row;
    logic [9:0] col;
    logic [3:0] len;
  } cmd_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/rpc_dev_fifo.sv
// Read-data FIFO between the backend stream and the pad-side read burst.
// Pointers carry one wrap bit so full and empty are distinguishable.
module rpc_dev_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push lands in, so push+pop is fine even when full.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rpc_dev_responder.sv
// Device-side RPC responder: decodes two-cycle commands from the pads,
// streams write beats to the backend and plays read bursts with DQS framing.
module rpc_dev_responder
  import rpc_dev_pkg::*;
#(
  parameter int unsigned ReadLatency = 4,
  parameter int unsigned FifoDepth   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csn_i,
  input  logic        stb_i,
  input  logic [15:0] db_i,
  output logic [15:0] db_o,
  output logic        db_oe_o,
  output logic        dqs_o,
  output logic        dqsn_o,
  output logic        dqs_oe_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic        cmd_we_o,
  output logic [1:0]  cmd_bank_o,
  output logic [9:0]  cmd_row_o,
  output logic [9:0]  cmd_col_o,
  output logic [3:0]  cmd_len_o,
  output logic        wdata_valid_o,
  output logic [15:0] wdata_o,
  input  logic        rdata_valid_i,
  input  logic [15:0] rdata_i,
  output logic        rdata_ready_o,
  output logic [2:0]  status_o,
  input  logic        clr_i
);

  localparam logic [3:0] LatInit = 4'(ReadLatency - 2);

  state_e      state_q;
  logic [3:0]  opcode_q;
  logic [1:0]  bank_q;
  logic [9:0]  row_q;
  logic [3:0]  cnt_q;
  logic [3:0]  len_q;
  cmd_t        cmd_q;
  logic [2:0]  status_q;

  logic        cmd_fire;
  logic        valid_op;
  logic        read_beat;
  logic        set_abort;
  logic        set_overrun;
  logic        set_underrun;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_push;
  logic [15:0] fifo_head;
  logic [15:0] beat_data;

  assign cmd_fire     = (state_q == CMD1) && !csn_i && stb_i;
  assign valid_op     = is_valid_op(opcode_q);
  // The first beat is loaded while leaving RD_PRE; cnt_q then holds beats still to load.
  assign read_beat    = (state_q == RD_PRE) || ((state_q == RD_DATA) && (cnt_q != 4'd0));
  assign set_abort    = ((state_q == CMD1) && !cmd_fire) || ((state_q == WR_DATA) && csn_i);
  assign set_overrun  = cmd_fire && valid_op && cmd_valid_o;
  assign set_underrun = read_beat && fifo_empty;
  assign beat_data    = fifo_empty ? 16'h0000 : fifo_head;

  assign rdata_ready_o = !fifo_full;
  assign fifo_push     = rdata_valid_i && rdata_ready_o;

  assign cmd_we_o   = cmd_q.we;
  assign cmd_bank_o = cmd_q.bank;
  assign cmd_row_o  = cmd_q.row;
  assign cmd_col_o  = cmd_q.col;
  assign cmd_len_o  = cmd_q.len;
  assign status_o   = status_q;

  rpc_dev_fifo #(
    .DEPTH  (FifoDepth),
    .DATA_W (16)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (state_q == RD_POST),
    .push_i  (fifo_push),
    .data_i  (rdata_i),
    .pop_i   (read_beat),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      opcode_q      <= '0;
      bank_q        <= '0;
      row_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      cmd_q         <= '0;
      cmd_valid_o   <= 1'b0;
      wdata_valid_o <= 1'b0;
      wdata_o       <= '0;
      db_o          <= '0;
      db_oe_o       <= 1'b0;
      dqs_o         <= 1'b0;
      dqsn_o        <= 1'b1;
      dqs_oe_o      <= 1'b0;
    end else begin
      wdata_valid_o <= 1'b0;
      if (cmd_valid_o && cmd_ready_i) cmd_valid_o <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!csn_i && stb_i) begin
            opcode_q <= db_i[15:12];
            bank_q   <= db_i[11:10];
            row_q    <= db_i[9:0];
            state_q  <= CMD1;
          end
        end

        CMD1: begin
          state_q <= IDLE;
          // A command arriving while the previous one is still unaccepted is dropped.
          if (cmd_fire && valid_op && !cmd_valid_o) begin
            cmd_valid_o <= 1'b1;
            cmd_q.we    <= (opcode_q == OP_WRITE);
            cmd_q.bank  <= bank_q;
            cmd_q.row   <= row_q;
            cmd_q.col   <= db_i[9:0];
            cmd_q.len   <= db_i[13:10];
            len_q       <= db_i[13:10];
            if (opcode_q == OP_WRITE) begin
              state_q <= WR_DATA;
              cnt_q   <= db_i[13:10];
            end else begin
              state_q <= RD_WAIT;
              cnt_q   <= LatInit;
            end
          end
        end

        WR_DATA: begin
          if (csn_i) begin
            state_q <= IDLE;
          end else if (!stb_i) begin
            wdata_valid_o <= 1'b1;
            wdata_o       <= db_i;
            if (cnt_q == 4'd0) state_q <= IDLE;
            else               cnt_q   <= cnt_q - 4'd1;
          end
        end

        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= RD_PRE;
            dqs_oe_o <= 1'b1;
            dqs_o    <= 1'b0;
            dqsn_o   <= 1'b1;
            db_oe_o  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        RD_PRE: begin
          state_q <= RD_DATA;
          db_oe_o <= 1'b1;
          dqs_o   <= 1'b1;
          dqsn_o  <= 1'b0;
          db_o    <= beat_data;
          cnt_q   <= len_q;
        end

        RD_DATA: begin
          if (cnt_q == 4'd0) begin
            state_q <= RD_POST;
            dqs_o   <= 1'b0;
            dqsn_o  <= 1'b1;
            db_o    <= '0;
          end else begin
            cnt_q  <= cnt_q - 4'd1;
            dqs_o  <= ~dqs_o;
            dqsn_o <= dqs_o;
            db_o   <= beat_data;
          end
        end

        RD_POST: begin
          state_q  <= IDLE;
          db_oe_o  <= 1'b0;
          dqs_oe_o <= 1'b0;
          dqs_o    <= 1'b0;
          dqsn_o   <= 1'b1;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a fresh event in the clearing cycle survives the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) status_q <= '0;
    else         status_q <= (clr_i ? 3'b000 : status_q) | {set_underrun, set_overrun, set_abort};
  end

endmodule

// File: tb/tb_rpc_dev_responder.sv
// Directed and randomized bench for rpc_dev_responder against a queue-based
// model of the read FIFO, the handshake count and the sticky status flags.
module tb_rpc_dev_responder;

  localparam int ReadLatency = 4;
  localparam int FifoDepth   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csn, stb, cmd_ready, rdata_valid, clr;
  logic [15:0] db, rdata;
  logic [15:0] db_o, wdata_o;
  logic        db_oe_o, dqs_o, dqsn_o, dqs_oe_o;
  logic        cmd_valid_o, cmd_we_o, wdata_valid_o, rdata_ready_o;
  logic [1:0]  cmd_bank_o;
  logic [9:0]  cmd_row_o, cmd_col_o;
  logic [3:0]  cmd_len_o;
  logic [2:0]  status_o;

  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          exp_hs = 0;
  int          hs0;
  int          n;
  logic [2:0]  exp_status = 3'b000;
  logic [15:0] model_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && cmd_valid_o && cmd_ready) hs_count <= hs_count + 1;
  end

  rpc_dev_responder #(
    .ReadLatency (ReadLatency),
    .FifoDepth   (FifoDepth)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .csn_i         (csn),
    .stb_i         (stb),
    .db_i          (db),
    .db_o          (db_o),
    .db_oe_o       (db_oe_o),
    .dqs_o         (dqs_o),
    .dqsn_o        (dqsn_o),
    .dqs_oe_o      (dqs_oe_o),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_ready_i   (cmd_ready),
    .cmd_we_o      (cmd_we_o),
    .cmd_bank_o    (cmd_bank_o),
    .cmd_row_o     (cmd_row_o),
    .cmd_col_o     (cmd_col_o),
    .cmd_len_o     (cmd_len_o),
    .wdata_valid_o (wdata_valid_o),
    .wdata_o       (wdata_o),
    .rdata_valid_i (rdata_valid),
    .rdata_i       (rdata),
    .rdata_ready_o (rdata_ready_o),
    .status_o      (status_o),
    .clr_i         (clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    csn = 1'b1; stb = 1'b0; db = '0; clr = 1'b0; rdata_valid = 1'b0;
  endtask

  task automatic clr_status();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_status = 3'b000;
    chk("status_clear", status_o, 3'b000);
  endtask

  task automatic push_word(input logic [15:0] w);
    chk("rdata_ready", rdata_ready_o, model_q.size() < FifoDepth);
    rdata_valid = 1'b1; rdata = w;
    if (model_q.size() < FifoDepth) model_q.push_back(w);
    tick();
    rdata_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [1:0] bank, input logic [9:0] row,
                          input logic [9:0] col, input logic [3:0] len);
    csn = 1'b0; stb = 1'b1; db = {op, bank, row};
    tick();
    db = {2'b00, len, col};
    tick();
  endtask

  task automatic do_write(input logic [1:0] bank, input logic [9:0] row, input logic [9:0] col,
                          input logic [3:0] len, input logic [15:0] d0, input logic [15:0] step);
    logic [15:0] d;
    send_cmd(4'h1, bank, row, col, len);
    exp_hs++;
    chk("wr_cmd_valid", cmd_valid_o, 1);
    chk("wr_cmd_fields", {cmd_we_o, cmd_bank_o, cmd_row_o, cmd_col_o, cmd_len_o},
        {1'b1, bank, row, col, len});
    d = d0;
    for (int i = 0; i <= int'(len); i++) begin
      stb = 1'b0; db = d;
      tick();
      chk("wdata_valid", wdata_valid_o, 1);
      chk("wdata", wdata_o, d);
      d = d + step;
    end
    idle_bus();
    tick();
    chk("wdata_quiet", wdata_valid_o, 0);
    chk("wr_status", status_o, exp_status);
  endtask

  task automatic do_read(input logic [1:0] bank, input logic [9:0] row, input logic [9:0] col,
                         input logic [3:0] len);
    int          lat;
    logic [15:0] exp_d;
    csn = 1'b0; stb = 1'b1; db = {4'h2, bank, row};
    tick();
    lat = 0;
    db = {2'b00, len, col};
    tick();
    lat = 1;
    exp_hs++;
    chk("rd_cmd_valid", cmd_valid_o, 1);
    chk("rd_cmd_fields", {cmd_we_o, cmd_bank_o, cmd_row_o, cmd_col_o, cmd_len_o},
        {1'b0, bank, row, col, len});
    idle_bus();
    for (int k = 0; k < 40 && !dqs_oe_o; k++) begin
      tick();
      lat++;
    end
    chk("rd_latency", lat, ReadLatency);
    chk("pre_strobes", {dqs_oe_o, dqs_o, dqsn_o, db_oe_o}, 4'b1010);
    for (int i = 0; i <= int'(len); i++) begin
      tick();
      if (model_q.size() > 0) exp_d = model_q.pop_front();
      else begin
        exp_d = 16'h0000;
        exp_status[2] = 1'b1;
      end
      chk("beat_data", db_o, exp_d);
      chk("beat_strobes", {db_oe_o, dqs_oe_o, dqs_o, dqsn_o}, {2'b11, (i % 2 == 0), (i % 2 != 0)});
      chk("beat_status", status_o, exp_status);
    end
    tick();
    chk("post_strobes", {dqs_oe_o, dqs_o, dqsn_o}, 3'b101);
    tick();
    chk("post_release", {dqs_oe_o, db_oe_o}, 2'b00);
    model_q.delete();
    chk("post_ready", rdata_ready_o, 1);
  endtask

  initial begin
    csn = 1'b1; stb = 1'b0; db = '0; cmd_ready = 1'b1;
    rdata_valid = 1'b0; rdata = '0; clr = 1'b0;
    tick();
    tick();
    chk("rst_pads", {db_o, db_oe_o, dqs_o, dqsn_o, dqs_oe_o}, {16'h0000, 4'b0010});
    chk("rst_ctrl", {cmd_valid_o, wdata_valid_o, rdata_ready_o, status_o}, 6'b001000);
    #2 rst_n = 1'b1;
    tick();

    // Write burst bank 2 / row 0x155 / col 0x0AA / 4 beats
    hs0 = hs_count;
    do_write(2'd2, 10'h155, 10'h0AA, 4'd3, 16'h1111, 16'h1111);
    chk("wr_one_handshake", hs_count - hs0, 1);

    // Read of two preloaded words
    push_word(16'hBEEF);
    push_word(16'hCAFE);
    do_read(2'd0, 10'h020, 10'h040, 4'd1);

    // Four-beat read with only two words available
    clr_status();
    push_word(16'h1234);
    push_word(16'h5678);
    do_read(2'd1, 10'h011, 10'h022, 4'd3);
    chk("underrun_flag", status_o, 3'b100);
    clr_status();

    // Chip select lost after two of four write beats
    send_cmd(4'h1, 2'd1, 10'h0F0, 10'h00F, 4'd3);
    exp_hs++;
    for (int i = 0; i < 2; i++) begin
      stb = 1'b0; db = 16'hA000 + 16'(i);
      tick();
      chk("abort_beat", {wdata_valid_o, wdata_o}, {1'b1, 16'hA000 + 16'(i)});
    end
    csn = 1'b1;
    tick();
    exp_status[0] = 1'b1;
    chk("abort_flag", status_o, exp_status);
    csn = 1'b0; stb = 1'b0; db = 16'hDEAD;
    tick();
    chk("abort_idle", wdata_valid_o, 0);
    idle_bus();
    tick();
    clr_status();

    // Abort in the same cycle as a clear keeps the flag
    csn = 1'b0; stb = 1'b1; db = {4'h2, 2'd0, 10'h001};
    tick();
    csn = 1'b1; stb = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("set_over_clr", status_o, 3'b001);
    clr_status();

    // Unknown opcode is ignored silently
    send_cmd(4'h7, 2'd3, 10'h3AA, 10'h155, 4'd2);
    chk("badop_no_cmd", {cmd_valid_o, status_o}, 4'b0000);
    stb = 1'b0;
    tick();
    chk("badop_idle", wdata_valid_o, 0);
    idle_bus();
    tick();

    // Second command while the first is still unaccepted
    cmd_ready = 1'b0;
    do_write(2'd1, 10'h0AB, 10'h033, 4'd0, 16'h7777, 16'h0000);
    send_cmd(4'h1, 2'd3, 10'h3FF, 10'h3FF, 4'd5);
    exp_status[1] = 1'b1;
    chk("overrun_flag", status_o, 3'b010);
    chk("overrun_hold", {cmd_valid_o, cmd_we_o, cmd_bank_o, cmd_row_o, cmd_col_o, cmd_len_o},
        {2'b11, 2'd1, 10'h0AB, 10'h033, 4'd0});
    stb = 1'b0; db = 16'h5555;
    tick();
    chk("overrun_idle", wdata_valid_o, 0);
    idle_bus();
    cmd_ready = 1'b1;
    tick();
    chk("overrun_accept", cmd_valid_o, 0);
    clr_status();

    // Reset asserted in the middle of a read burst
    for (int i = 0; i < 3; i++) push_word(16'(32'hC000 + i));
    send_cmd(4'h2, 2'd0, 10'h001, 10'h002, 4'd3);
    exp_hs++;
    idle_bus();
    for (int k = 0; k < 40 && !db_oe_o; k++) tick();
    chk("mid_burst_reached", db_oe_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pads", {db_oe_o, dqs_oe_o, dqs_o, dqsn_o}, 4'b0001);
    chk("async_rst_data", {db_o, status_o}, 19'h0);
    #1 rst_n = 1'b1;
    model_q.delete();
    exp_status = 3'b000;
    tick();
    chk("rst_ready", {rdata_ready_o, cmd_valid_o}, 2'b10);
    do_read(2'd2, 10'h0C0, 10'h0D0, 4'd0);
    clr_status();

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom));
      end else begin
        n = $urandom_range(0, 6);
        for (int j = 0; j < n; j++) push_word(16'($urandom));
        do_read(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
                10'($urandom_range(0, 1023)), 4'($urandom_range(0, 7)));
      end
      clr_status();
    end

    tick();
    chk("handshakes", hs_count, exp_hs);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
